// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit RISC CPU.
// Optional feature: define CPU_ILLEGAL_TRAP_EN to halt on undefined opcodes.
module cpu_ctrl_fsm #(
  parameter int IW      = 8,
  parameter int TMO_CYC = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] instr,
  input  logic          zero,
  input  logic          mem_ready,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          addr_sel,
  output logic          ir_ld,
  output logic          pc_inc,
  output logic          pc_ld,
  output logic          opnd_ld,
  output logic          acc_ld,
  output logic          acc_src,
  output logic [3:0]    alu_op,
  output logic          halted,
  output logic          illegal,
  output logic          timeout
);

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3,
                         OP_NOT = 4'h4, OP_RD  = 4'h5, OP_WR  = 4'h6, OP_BR  = 4'h7,
                         OP_BRZ = 4'h8, OP_HLT = 4'h9;
  localparam int CW = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_OPRD, S_EXEC, S_MEMWR, S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic          z_q, z_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic          timeout_q, timeout_d;
  logic          trap_d;
  logic [3:0]    opc;
  logic          wait_st;
  logic          unused_opnd;

  assign opc         = instr[IW-1 -: 4];
  assign unused_opnd = ^instr[IW-5:0];
  assign wait_st     = (state_q == S_FETCH) || (state_q == S_OPRD) || (state_q == S_MEMWR);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    z_d       = z_q;
    timeout_d = timeout_q;
    trap_d    = 1'b0;
    wcnt_d    = '0;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        op_d = opc;
        case (opc)
          OP_NOT:                        state_d = S_EXEC;
          OP_ADD, OP_SUB, OP_AND, OP_RD: state_d = S_OPRD;
          OP_WR:                         state_d = S_MEMWR;
          OP_HLT:                        state_d = S_HALT;
          OP_NOP, OP_BR, OP_BRZ:         state_d = S_FETCH;
          default: begin
`ifdef CPU_ILLEGAL_TRAP_EN
            state_d = S_HALT;
            trap_d  = 1'b1;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_OPRD:   if (mem_ready) state_d = (op_q == OP_RD) ? S_FETCH : S_EXEC;
      S_EXEC: begin
        z_d     = zero;
        state_d = S_FETCH;
      end
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
    // The cycle that would bring the count to TMO_CYC halts instead; mem_ready=1 never counts.
    if (wait_st && !mem_ready) begin
      if ((TMO_CYC != 0) && (wcnt_q == CW'(TMO_CYC - 1))) begin
        state_d   = S_HALT;
        timeout_d = 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_RST;
      op_q      <= OP_NOP;
      z_q       <= 1'b0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      z_q       <= z_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef CPU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         illegal_q <= 1'b0;
    else if (trap_d) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  logic unused_trap;
  assign unused_trap = trap_d;
  assign illegal     = 1'b0;
`endif

  assign halted  = (state_q == S_HALT);
  assign timeout = timeout_q;

  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    ir_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    opnd_ld  = 1'b0;
    acc_ld   = 1'b0;
    acc_src  = 1'b0;
    alu_op   = OP_NOP;
    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = mem_ready;
        pc_inc = mem_ready;
      end
      S_DECODE: begin
        if (opc == OP_BR)  pc_ld = 1'b1;
        if (opc == OP_BRZ) pc_ld = z_q;
      end
      S_OPRD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          if (op_q == OP_RD) begin
            acc_ld  = 1'b1;
            acc_src = 1'b1;
          end else begin
            opnd_ld = 1'b1;
          end
        end
      end
      S_EXEC: begin
        alu_op = op_q;
        acc_ld = 1'b1;
      end
      S_MEMWR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Scoreboard bench for cpu_ctrl_fsm: directed per-cycle vectors queue expected outputs, a monitor checks them.
module tb_cpu_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] instr = 8'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, opnd_ld, acc_ld, acc_src;
  logic [3:0] alu_op;
  logic       halted, illegal, timeout;

  cpu_ctrl_fsm #(.IW(8), .TMO_CYC(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_ld(ir_ld),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .opnd_ld(opnd_ld), .acc_ld(acc_ld),
    .acc_src(acc_src), .alu_op(alu_op), .halted(halted), .illegal(illegal),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] B_RD = 16'h8000, B_WR = 16'h4000, B_AS = 16'h2000, B_IR = 16'h1000,
                          B_PI = 16'h0800, B_PL = 16'h0400, B_OL = 16'h0200, B_AL = 16'h0100,
                          B_SRC = 16'h0080, B_H = 16'h0004, B_IL = 16'h0002, B_TO = 16'h0001;
  localparam logic [15:0] FD = B_RD | B_IR | B_PI;

  function automatic logic [15:0] aop(input logic [3:0] op);
    return {9'd0, op, 3'd0};
  endfunction

  logic [15:0] expq[$];
  string       nmq[$];
  int          checks = 0;
  int          failures = 0;

  task automatic step(input logic r, input logic mr, input logic z, input logic [7:0] ins,
                      input logic [15:0] exp, input string nm);
    @(posedge clk);
    #1;
    rst = r; mem_ready = mr; zero = z; instr = ins;
    expq.push_back(exp);
    nmq.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [15:0] e, a;
      string n;
      e = expq.pop_front();
      n = nmq.pop_front();
      a = {mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, opnd_ld, acc_ld, acc_src,
           alu_op, halted, illegal, timeout};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s: outputs got=%h expected=%h", n, a, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  initial begin
    step(1, 1, 0, 8'h00, 16'h0, "reset");
    step(0, 1, 0, 8'h00, 16'h0, "rst_state");
    // NOP x2: two cycles each
    step(0, 1, 0, 8'h00, FD,    "nop_fetch");
    step(0, 1, 0, 8'h00, 16'h0, "nop_decode");
    step(0, 1, 0, 8'h00, FD,    "nop2_fetch");
    step(0, 1, 0, 8'h00, 16'h0, "nop2_decode");
    // ADD 0x3
    step(0, 1, 0, 8'h13, FD,                  "add_fetch");
    step(0, 1, 0, 8'h13, 16'h0,               "add_decode");
    step(0, 1, 0, 8'h13, B_RD | B_AS | B_OL,  "add_oprd");
    step(0, 1, 0, 8'h13, B_AL | aop(4'h1),    "add_exec");
    // RD
    step(0, 1, 0, 8'h52, FD,                        "rd_fetch");
    step(0, 1, 0, 8'h52, 16'h0,                     "rd_decode");
    step(0, 1, 0, 8'h52, B_RD | B_AS | B_AL | B_SRC, "rd_oprd");
    // NOT
    step(0, 1, 0, 8'h40, FD,               "not_fetch");
    step(0, 1, 0, 8'h40, 16'h0,            "not_decode");
    step(0, 1, 0, 8'h40, B_AL | aop(4'h4), "not_exec");
    // SUB giving zero, then BRZ taken
    step(0, 1, 0, 8'h24, FD,                 "sub_fetch");
    step(0, 1, 0, 8'h24, 16'h0,              "sub_decode");
    step(0, 1, 0, 8'h24, B_RD | B_AS | B_OL, "sub_oprd");
    step(0, 1, 1, 8'h24, B_AL | aop(4'h2),   "sub_exec_z1");
    step(0, 1, 0, 8'h89, FD,                 "brz_fetch");
    step(0, 1, 0, 8'h89, B_PL,               "brz_taken");
    // RD leaves z untouched
    step(0, 1, 0, 8'h51, FD,                         "rd2_fetch");
    step(0, 1, 0, 8'h51, 16'h0,                      "rd2_decode");
    step(0, 1, 0, 8'h51, B_RD | B_AS | B_AL | B_SRC, "rd2_oprd");
    step(0, 1, 0, 8'h89, FD,                         "brz2_fetch");
    step(0, 1, 0, 8'h89, B_PL,                       "brz_after_rd");
    // SUB non-zero, BRZ not taken
    step(0, 1, 0, 8'h24, FD,                 "sub2_fetch");
    step(0, 1, 0, 8'h24, 16'h0,              "sub2_decode");
    step(0, 1, 0, 8'h24, B_RD | B_AS | B_OL, "sub2_oprd");
    step(0, 1, 0, 8'h24, B_AL | aop(4'h2),   "sub2_exec_z0");
    step(0, 1, 0, 8'h89, FD,                 "brz3_fetch");
    step(0, 1, 0, 8'h89, 16'h0,              "brz_not_taken");
    // BR unconditional
    step(0, 1, 0, 8'h7A, FD,   "br_fetch");
    step(0, 1, 0, 8'h7A, B_PL, "br_decode");
    // WR with 5 wait states
    step(0, 1, 0, 8'h6C, FD,    "wr_fetch");
    step(0, 1, 0, 8'h6C, 16'h0, "wr_decode");
    for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h6C, B_WR | B_AS, "wr_wait");
    step(0, 1, 0, 8'h6C, B_WR | B_AS, "wr_done");
    // fetch wait states, then WR timing out after 16 low cycles
    step(0, 0, 0, 8'h6C, B_RD, "fetch_wait");
    step(0, 0, 0, 8'h6C, B_RD, "fetch_wait");
    step(0, 1, 0, 8'h6C, FD,    "wr2_fetch");
    step(0, 1, 0, 8'h6C, 16'h0, "wr2_decode");
    for (int i = 0; i < 16; i++) step(0, 0, 0, 8'h6C, B_WR | B_AS, "wr2_wait");
    step(0, 1, 0, 8'h6C, B_H | B_TO, "timeout_halt");
    step(0, 1, 0, 8'h6C, B_H | B_TO, "timeout_hold");
    // reset clears flags
    step(1, 1, 0, 8'h00, 16'h0, "reset2");
    step(0, 1, 0, 8'h00, 16'h0, "rst2_state");
    // HLT absorbs, ignores mem_ready
    step(0, 1, 0, 8'h90, FD,    "hlt_fetch");
    step(0, 1, 0, 8'h90, 16'h0, "hlt_decode");
    step(0, 1, 0, 8'h90, B_H,   "hlt_state");
    step(0, 1, 0, 8'h00, B_H,   "hlt_hold");
    // reset mid-OPRD
    step(1, 1, 0, 8'h00, 16'h0, "reset3");
    step(0, 1, 0, 8'h00, 16'h0, "rst3_state");
    step(0, 1, 0, 8'h13, FD,          "add3_fetch");
    step(0, 1, 0, 8'h13, 16'h0,       "add3_decode");
    step(0, 0, 0, 8'h13, B_RD | B_AS, "add3_oprd_wait");
    step(1, 0, 0, 8'h13, 16'h0,       "rst_mid_oprd");
    step(0, 1, 0, 8'h00, 16'h0,       "rst4_state");
    step(0, 1, 0, 8'h00, FD,          "refetch");
    step(0, 1, 0, 8'h00, 16'h0,       "refetch_decode");
    // undefined opcode 0xF
    step(0, 1, 0, 8'hF0, FD,    "ill_fetch");
    step(0, 1, 0, 8'hF0, 16'h0, "ill_decode");
`ifdef CPU_ILLEGAL_TRAP_EN
    step(0, 1, 0, 8'h00, B_H | B_IL, "ill_trap");
    step(0, 1, 0, 8'h00, B_H | B_IL, "ill_trap_hold");
`else
    step(0, 1, 0, 8'h00, FD,    "ill_as_nop_fetch");
    step(0, 1, 0, 8'h00, 16'h0, "ill_as_nop_decode");
`endif
    step(1, 1, 0, 8'h00, 16'h0, "final_reset");
    @(posedge clk);
    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    if (expq.size() > 0) begin
      failures++;
      $display("FAIL drain: pending=%0d expected=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
